ds_operand_collector: RTL and testbench

- Parametrised decode-stage operand collector with a pipeline register and valid/allowin handshake. It sits between the fetch stage (fs) and the execute stage (es).
- Holds one decoded instruction and resolves two source operands. Resolution uses the register file plus NUM_FWD forwarding channels from downstream stages, youngest stage first.
- Raises an interlock while the highest-priority matching producer has no result yet. Supports flush and a saturating stall-cycle counter.

---
 rtl/ds_operand_collector.sv | 132 +++++++++++++
 tb/tb_ds_operand_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ds_operand_collector.sv
// Decode-stage operand collector: holds one decoded instruction, resolves two
// source operands from the register file or forwarding channels, and interlocks on unready producers.
module ds_operand_collector #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_FWD   = 3,
   parameter int unsigned PAYLOAD_W = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fs_to_ds_valid,
   output logic                        ds_allowin,
   input  logic [ADDR_W-1:0]           fs_src1_addr,
   input  logic [ADDR_W-1:0]           fs_src2_addr,
   input  logic                        fs_src1_used,
   input  logic                        fs_src2_used,
   input  logic [PAYLOAD_W-1:0]        fs_payload,
   input  logic                        es_allowin,
   output logic                        ds_to_es_valid,
   output logic [PAYLOAD_W-1:0]        ds_payload,
   output logic [DATA_W-1:0]           ds_src1_value,
   output logic [DATA_W-1:0]           ds_src2_value,
   input  logic                        flush,
   output logic [ADDR_W-1:0]           rf_raddr1,
   output logic [ADDR_W-1:0]           rf_raddr2,
   input  logic [DATA_W-1:0]           rf_rdata1,
   input  logic [DATA_W-1:0]           rf_rdata2,
   input  logic [NUM_FWD-1:0]          fwd_valid,
   input  logic [NUM_FWD-1:0]          fwd_ready,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_dest,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
   output logic [CNT_W-1:0]            stall_cnt
);

   logic                 ds_valid_q, ds_valid_d;
   logic [ADDR_W-1:0]    src1_addr_q, src2_addr_q;
   logic                 src1_used_q, src2_used_q;
   logic [PAYLOAD_W-1:0] payload_q;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

   logic                 src1_hit, src2_hit;
   logic                 src1_rdy, src2_rdy;
   logic                 hazard1, hazard2;
   logic                 ds_ready_go;
   logic                 load_en;

   // Youngest matching channel wins; scanning high-to-low lets the lowest index overwrite.
   function automatic void resolve(
      input  logic [ADDR_W-1:0] addr,
      input  logic [DATA_W-1:0] rf_val,
      output logic [DATA_W-1:0] val,
      output logic              hit,
      output logic              rdy
   );
      val = rf_val;
      hit = 1'b0;
      rdy = 1'b1;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_dest[i*ADDR_W +: ADDR_W] == addr)) begin
            val = fwd_data[i*DATA_W +: DATA_W];
            hit = 1'b1;
            rdy = fwd_ready[i];
         end
      end
      if (addr == '0) begin
         val = '0;
         hit = 1'b0;
         rdy = 1'b1;
      end
   endfunction

   always_comb begin
      ds_src1_value = '0;
      ds_src2_value = '0;
      src1_hit      = 1'b0;
      src2_hit      = 1'b0;
      src1_rdy      = 1'b1;
      src2_rdy      = 1'b1;
      resolve(src1_addr_q, rf_rdata1, ds_src1_value, src1_hit, src1_rdy);
      resolve(src2_addr_q, rf_rdata2, ds_src2_value, src2_hit, src2_rdy);
   end

   assign hazard1        = src1_used_q && src1_hit && !src1_rdy;
   assign hazard2        = src2_used_q && src2_hit && !src2_rdy;
   assign ds_ready_go    = !(hazard1 || hazard2);
   assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
   assign ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;
   assign load_en        = fs_to_ds_valid && ds_allowin;

   assign ds_payload = payload_q;
   assign rf_raddr1  = src1_addr_q;
   assign rf_raddr2  = src2_addr_q;
   assign stall_cnt  = stall_cnt_q;

   // Flush beats a simultaneous accept; only true interlock cycles are counted.
   always_comb begin
      ds_valid_d  = ds_valid_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         ds_valid_d = 1'b0;
      end else if (ds_allowin) begin
         ds_valid_d = fs_to_ds_valid;
      end
      if (ds_valid_q && !ds_ready_go && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ds_valid_q  <= 1'b0;
         src1_addr_q <= '0;
         src2_addr_q <= '0;
         src1_used_q <= 1'b0;
         src2_used_q <= 1'b0;
         payload_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         ds_valid_q  <= ds_valid_d;
         stall_cnt_q <= stall_cnt_d;
         if (load_en) begin
            src1_addr_q <= fs_src1_addr;
            src2_addr_q <= fs_src2_addr;
            src1_used_q <= fs_src1_used;
            src2_used_q <= fs_src2_used;
            payload_q   <= fs_payload;
         end
      end
   end

endmodule

// File: tb/tb_ds_operand_collector.sv
// Directed bench for ds_operand_collector (CNT_W=2 so counter saturation is reachable).
module tb_ds_operand_collector;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned NUM_FWD   = 3;
   localparam int unsigned PAYLOAD_W = 64;
   localparam int unsigned CNT_W     = 2;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       fs_to_ds_valid;
   logic                       ds_allowin;
   logic [ADDR_W-1:0]          fs_src1_addr, fs_src2_addr;
   logic                       fs_src1_used, fs_src2_used;
   logic [PAYLOAD_W-1:0]       fs_payload;
   logic                       es_allowin;
   logic                       ds_to_es_valid;
   logic [PAYLOAD_W-1:0]       ds_payload;
   logic [DATA_W-1:0]          ds_src1_value, ds_src2_value;
   logic                       flush;
   logic [ADDR_W-1:0]          rf_raddr1, rf_raddr2;
   logic [DATA_W-1:0]          rf_rdata1, rf_rdata2;
   logic [NUM_FWD-1:0]         fwd_valid, fwd_ready;
   logic [NUM_FWD*ADDR_W-1:0]  fwd_dest;
   logic [NUM_FWD*DATA_W-1:0]  fwd_data;
   logic [CNT_W-1:0]           stall_cnt;

   int n_chk = 0;
   int n_bad = 0;

   ds_operand_collector #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
      .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .fs_to_ds_valid(fs_to_ds_valid), .ds_allowin(ds_allowin),
      .fs_src1_addr(fs_src1_addr), .fs_src2_addr(fs_src2_addr),
      .fs_src1_used(fs_src1_used), .fs_src2_used(fs_src2_used),
      .fs_payload(fs_payload), .es_allowin(es_allowin),
      .ds_to_es_valid(ds_to_es_valid), .ds_payload(ds_payload),
      .ds_src1_value(ds_src1_value), .ds_src2_value(ds_src2_value),
      .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
      .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
      fwd_dest[ch*ADDR_W +: ADDR_W] = dest;
      fwd_data[ch*DATA_W +: DATA_W] = data;
   endtask

   task automatic offer(input logic [ADDR_W-1:0] a1, input logic u1,
                        input logic [ADDR_W-1:0] a2, input logic u2,
                        input logic [PAYLOAD_W-1:0] pl);
      fs_to_ds_valid = 1'b1;
      fs_src1_addr   = a1;
      fs_src1_used   = u1;
      fs_src2_addr   = a2;
      fs_src2_used   = u2;
      fs_payload     = pl;
      step();
      fs_to_ds_valid = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      fs_to_ds_valid = 1'b0;
      fs_src1_addr = '0; fs_src2_addr = '0;
      fs_src1_used = 1'b0; fs_src2_used = 1'b0;
      fs_payload = '0;
      es_allowin = 1'b1;
      flush = 1'b0;
      rf_rdata1 = '0; rf_rdata2 = '0;
      fwd_valid = '0; fwd_ready = '0;
      fwd_dest = '0; fwd_data = '0;

      #3;
      chk("rst_valid", 64'(ds_to_es_valid), 64'd0);
      chk("rst_allowin", 64'(ds_allowin), 64'd1);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_payload", ds_payload, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // No hazard: regfile values, one-cycle latency
      rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
      chk("nh_allowin", 64'(ds_allowin), 64'd1);
      offer(5'd3, 1'b1, 5'd4, 1'b1, 64'hDEAD_BEEF_0123_4567);
      chk("nh_valid", 64'(ds_to_es_valid), 64'd1);
      chk("nh_v1", 64'(ds_src1_value), 64'h11);
      chk("nh_v2", 64'(ds_src2_value), 64'h22);
      chk("nh_payload", ds_payload, 64'hDEAD_BEEF_0123_4567);
      chk("nh_raddr1", 64'(rf_raddr1), 64'd3);
      chk("nh_raddr2", 64'(rf_raddr2), 64'd4);
      step();
      chk("nh_drain", 64'(ds_to_es_valid), 64'd0);

      // Priority: ch0 beats ch1; held under backpressure
      set_ch(0, 5'd5, 32'hA);
      set_ch(1, 5'd5, 32'hB);
      fwd_valid = 3'b011; fwd_ready = 3'b011;
      es_allowin = 1'b0;
      offer(5'd5, 1'b1, 5'd9, 1'b1, 64'h1);
      chk("pri_ch0", 64'(ds_src1_value), 64'hA);
      chk("pri_valid", 64'(ds_to_es_valid), 64'd1);
      chk("pri_bp_allowin", 64'(ds_allowin), 64'd0);
      fwd_ready = 3'b010;
      #1;
      chk("pri_low_ready_ignored", 64'(ds_to_es_valid), 64'd0);
      fwd_ready = 3'b011;
      fwd_valid = 3'b010;
      #1;
      chk("pri_ch1", 64'(ds_src1_value), 64'hB);
      step();
      chk("pri_bp_nocount", 64'(stall_cnt), 64'd0);
      es_allowin = 1'b1;
      step();
      fwd_valid = '0;

      // Load interlock for two cycles on ch0
      set_ch(0, 5'd7, 32'h77);
      fwd_valid = 3'b001; fwd_ready = 3'b000;
      offer(5'd1, 1'b1, 5'd7, 1'b1, 64'h2);
      chk("ld_c0_valid", 64'(ds_to_es_valid), 64'd0);
      chk("ld_c0_allowin", 64'(ds_allowin), 64'd0);
      chk("ld_c0_cnt", 64'(stall_cnt), 64'd0);
      step();
      chk("ld_c1_valid", 64'(ds_to_es_valid), 64'd0);
      chk("ld_c1_cnt", 64'(stall_cnt), 64'd1);
      step();
      fwd_ready = 3'b001;
      #1;
      chk("ld_go_valid", 64'(ds_to_es_valid), 64'd1);
      chk("ld_go_v2", 64'(ds_src2_value), 64'h77);
      chk("ld_go_v1", 64'(ds_src1_value), 64'h11);
      chk("ld_go_cnt", 64'(stall_cnt), 64'd2);
      step();
      chk("ld_after_cnt", 64'(stall_cnt), 64'd2);

      // Register zero ignores a not-ready ch0 aimed at r0
      rf_rdata1 = 32'h55; rf_rdata2 = 32'h66;
      set_ch(0, 5'd0, 32'h99);
      fwd_valid = 3'b001; fwd_ready = 3'b000;
      offer(5'd0, 1'b1, 5'd2, 1'b1, 64'h3);
      chk("r0_valid", 64'(ds_to_es_valid), 64'd1);
      chk("r0_v1", 64'(ds_src1_value), 64'd0);
      chk("r0_v2", 64'(ds_src2_value), 64'h66);
      step();

      // Unused source matching a not-ready producer never stalls
      rf_rdata1 = 32'h11;
      set_ch(0, 5'd6, 32'h99);
      offer(5'd3, 1'b1, 5'd6, 1'b0, 64'h4);
      chk("unused_valid", 64'(ds_to_es_valid), 64'd1);
      chk("unused_v2", 64'(ds_src2_value), 64'h99);
      chk("unused_v1", 64'(ds_src1_value), 64'h11);
      step();
      chk("unused_cnt", 64'(stall_cnt), 64'd2);
      fwd_valid = '0;

      // Flush collides with an accept: instruction dropped
      flush = 1'b1;
      offer(5'd3, 1'b1, 5'd4, 1'b1, 64'h5);
      flush = 1'b0;
      #1;
      chk("fl_valid", 64'(ds_to_es_valid), 64'd0);
      chk("fl_allowin", 64'(ds_allowin), 64'd1);

      // Flush of a stalled instruction: not counted, stage empties
      set_ch(0, 5'd7, 32'h77);
      fwd_valid = 3'b001; fwd_ready = 3'b000;
      offer(5'd1, 1'b0, 5'd7, 1'b1, 64'h6);
      flush = 1'b1;
      #1;
      chk("fl_hold_valid", 64'(ds_to_es_valid), 64'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_hold_cnt", 64'(stall_cnt), 64'd2);
      chk("fl_hold_allowin", 64'(ds_allowin), 64'd1);

      // Saturation after 5 hazard cycles, then async reset mid-cycle
      offer(5'd1, 1'b0, 5'd7, 1'b1, 64'h7);
      for (int k = 0; k < 5; k++) step();
      chk("sat_cnt", 64'(stall_cnt), 64'd3);
      chk("sat_allowin", 64'(ds_allowin), 64'd0);
      fwd_ready = 3'b001;
      #1;
      reset = 1'b1;
      #1;
      chk("arst_cnt", 64'(stall_cnt), 64'd0);
      chk("arst_valid", 64'(ds_to_es_valid), 64'd0);
      chk("arst_allowin", 64'(ds_allowin), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("post_rst_valid", 64'(ds_to_es_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
